// File: rtl/mult_seq.sv
// mult_seq: control FSM for an 8x8 signed shift-add multiplier driving external A/B shift registers.
// Optional build macro SKIP_ZERO_ADD_EN merges the shift into ADD when the multiplier bit is zero.
module mult_seq (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Clr_Ld,
    input  logic [7:0] S,
    input  logic [7:0] A,
    input  logic       M,
    output logic [7:0] Sum,
    output logic       X,
    output logic       Ld_A,
    output logic       Ld_B,
    output logic       Clr_A,
    output logic       Shift_En,
    output logic       Busy,
    output logic       Done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t     state_r;
    state_t     state_s;
    logic [2:0] cnt_r;
    logic [2:0] cnt_s;
    logic       x_r;
    logic       x_s;
    logic [8:0] sum9_s;
    logic       ld_a_s;
    logic       ld_b_s;
    logic       clr_a_s;
    logic       shift_en_s;

    // Sign-extended add; the final partial product carries the multiplier sign weight, so it subtracts
    always_comb begin
        if (cnt_r == 3'd7) begin
            sum9_s = {A[7], A} - {S[7], S};
        end else begin
            sum9_s = {A[7], A} + {S[7], S};
        end
    end

    // Next-state, counter, sign-bit and strobe decode
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        x_s        = x_r;
        ld_a_s     = 1'b0;
        ld_b_s     = 1'b0;
        clr_a_s    = 1'b0;
        shift_en_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (Clr_Ld) begin
                    clr_a_s = 1'b1;
                    ld_b_s  = 1'b1;
                    x_s     = 1'b0;
                end else if (Run) begin
                    state_s = ADD;
                    cnt_s   = 3'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            ADD: begin
                if (M) begin
                    ld_a_s  = 1'b1;
                    x_s     = sum9_s[8];
                    state_s = SHIFT;
                end else begin
`ifdef SKIP_ZERO_ADD_EN
                    shift_en_s = 1'b1;
                    if (cnt_r == 3'd7) begin
                        state_s = HOLD;
                    end else begin
                        cnt_s   = cnt_r + 3'd1;
                        state_s = ADD;
                    end
`else
                    state_s = SHIFT;
`endif
                end
            end
            SHIFT: begin
                shift_en_s = 1'b1;
                // cnt parks at 7 in HOLD and only returns to 0 on the way back through IDLE
                if (cnt_r == 3'd7) begin
                    state_s = HOLD;
                end else begin
                    cnt_s   = cnt_r + 3'd1;
                    state_s = ADD;
                end
            end
            HOLD: begin
                if (Run) begin
                    state_s = HOLD;
                end else begin
                    state_s = IDLE;
                    cnt_s   = 3'd0;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 3'd0;
            end
        endcase
    end

    // State, counter and sign-extension registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r <= IDLE;
            cnt_r   <= 3'd0;
            x_r     <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            x_r     <= x_s;
        end
    end

    // Strobes are forced low while Reset is held so nothing reaches the datapath asynchronously
    assign Ld_A     = ld_a_s & Reset;
    assign Ld_B     = ld_b_s & Reset;
    assign Clr_A    = clr_a_s & Reset;
    assign Shift_En = shift_en_s & Reset;
    assign Busy     = (state_r == ADD) || (state_r == SHIFT);
    assign Done     = (state_r == HOLD);
    assign Sum      = sum9_s[7:0];
    assign X        = x_r;

endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: directed self-checking bench for mult_seq with a behavioural model of the A/B registers.
module tb_mult_seq;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Run;
    logic       Clr_Ld;
    logic [7:0] S;
    logic [7:0] Sum;
    logic       X;
    logic       Ld_A;
    logic       Ld_B;
    logic       Clr_A;
    logic       Shift_En;
    logic       Busy;
    logic       Done;
    logic [7:0] a_m = 8'h00;
    logic [7:0] b_m = 8'h00;
    int         tests_run = 0;
    int         tests_failed = 0;
    int         lat;

    mult_seq dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Run      (Run),
        .Clr_Ld   (Clr_Ld),
        .S        (S),
        .A        (a_m),
        .M        (b_m[0]),
        .Sum      (Sum),
        .X        (X),
        .Ld_A     (Ld_A),
        .Ld_B     (Ld_B),
        .Clr_A    (Clr_A),
        .Shift_En (Shift_En),
        .Busy     (Busy),
        .Done     (Done)
    );

    always #5 Clk = ~Clk;

    // Downstream accumulator A and multiplier B shift registers
    always @(posedge Clk) begin
        if (Clr_A) a_m <= 8'h00;
        else if (Ld_A) a_m <= Sum;
        else if (Shift_En) a_m <= {X, a_m[7:1]};
        if (Ld_B) b_m <= S;
        else if (Shift_En) b_m <= {a_m[0], b_m[7:1]};
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic int exp_lat(input int pc);
`ifdef SKIP_ZERO_ADD_EN
        return 8 + pc;
`else
        return 16 + 0 * pc;
`endif
    endfunction

    task automatic load_b(input logic [7:0] v);
        Clr_Ld = 1'b1;
        S      = v;
        tick();
        Clr_Ld = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!Done && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic start_and_wait(input logic [7:0] s_v, output int n);
        S   = s_v;
        Run = 1'b1;
        tick();
        chk("busy_after_start", 16'(Busy), 16'h0001);
        wait_done(n);
    endtask

    initial begin
        Reset  = 1'b0;
        Run    = 1'b0;
        Clr_Ld = 1'b1;
        S      = 8'h00;
        #12;
        chk("reset_outputs", 16'({Ld_A, Ld_B, Clr_A, Shift_En, Busy, Done, X}), 16'h0000);
        Clr_Ld = 1'b0;
        Reset  = 1'b1;
        tick();
        chk("idle_after_reset", 16'({Busy, Done}), 16'h0000);

        // 7 x -3 = -21
        Clr_Ld = 1'b1;
        S      = 8'hFD;
        #1;
        chk("clr_ld_strobes", 16'({Clr_A, Ld_B, Ld_A, Shift_En}), 16'h000C);
        tick();
        Clr_Ld = 1'b0;
        chk("b_loaded", {a_m, b_m}, 16'h00FD);
        S = 8'h07;
        #1;
        chk("sum_idle", 16'(Sum), 16'h0007);
        start_and_wait(8'h07, lat);
        chk("lat_7x-3", 16'(lat), 16'(exp_lat(7)));
        chk("prod_7x-3", {a_m, b_m}, 16'hFFEB);
        chk("done_hold", 16'({Done, Busy}), 16'h0002);
        chk("x_hold_neg", 16'(X), 16'h0001);
        tick();
        chk("hold_stays", 16'(Done), 16'h0001);
        chk("hold_preserve", {a_m, b_m}, 16'hFFEB);
        Run = 1'b0;
        tick();
        chk("hold_exit", 16'(Done), 16'h0000);

        // Run and Clr_Ld together: clear wins, no start
        Clr_Ld = 1'b1;
        Run    = 1'b1;
        S      = 8'h03;
        #1;
        chk("both_strobes", 16'({Clr_A, Ld_B}), 16'h0003);
        tick();
        Clr_Ld = 1'b0;
        chk("both_stay_idle", 16'(Busy), 16'h0000);
        chk("x_cleared", 16'(X), 16'h0000);
        start_and_wait(8'h02, lat);
        chk("lat_2x3", 16'(lat), 16'(exp_lat(2)));
        chk("prod_2x3", {a_m, b_m}, 16'h0006);
        for (int i = 0; i < 3; i++) tick();
        chk("no_restart", 16'({Done, Busy}), 16'h0002);
        chk("no_restart_prod", {a_m, b_m}, 16'h0006);
        Run = 1'b0;
        tick();
        chk("release_idle", 16'(Done), 16'h0000);
        start_and_wait(8'h02, lat);
        chk("prod_2x6", {a_m, b_m}, 16'h000C);
        Run = 1'b0;
        tick();

        // -128 x -128, last step subtracts
        load_b(8'h80);
        start_and_wait(8'h80, lat);
        chk("lat_m128", 16'(lat), 16'(exp_lat(1)));
        chk("prod_m128", {a_m, b_m}, 16'h4000);
        chk("x_m128", 16'(X), 16'h0000);
        Run = 1'b0;
        tick();

        // 5 x 1, single non-zero multiplier bit
        load_b(8'h01);
        start_and_wait(8'h05, lat);
        chk("lat_5x1", 16'(lat), 16'(exp_lat(1)));
        chk("prod_5x1", {a_m, b_m}, 16'h0005);
        Run = 1'b0;
        tick();

        // Asynchronous reset mid-operation
        load_b(8'h03);
        S   = 8'h02;
        Run = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) tick();
        chk("busy_before_rst", 16'(Busy), 16'h0001);
        Reset = 1'b0;
        #1;
        chk("midop_reset_outs", 16'({Ld_A, Ld_B, Clr_A, Shift_En, Busy, Done, X}), 16'h0000);
        #3;
        Reset = 1'b1;
        #1;
        chk("idle_after_release", 16'(Busy), 16'h0000);
        tick();
        chk("restart_after_idle", 16'(Busy), 16'h0001);
        wait_done(lat);
        chk("done_after_restart", 16'(Done), 16'h0001);
        Run = 1'b0;
        tick();
        chk("final_idle", 16'({Done, Busy}), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 Clk  input  1  sole clock; all state updates on rising edge.
REQ-002 Reset  input  1  asynchronous, active-low; low forces reset state immediately, independent of Clk.
REQ-003 Run  input  1  level start request, sampled in IDLE.
REQ-004 Clr_Ld  input  1  level; in IDLE requests clear of accumulator A and load of multiplier B.
REQ-005 S  input  8  signed multiplicand, two's complement, held stable by user during operation.
REQ-006 A  input  8  current contents of downstream 8-bit accumulator shift register.
REQ-007 M  input  1  current multiplier LSB (B[0]) from downstream multiplier shift register.
REQ-008 Sum  output  8  low 8 bits of add/subtract result; drives accumulator parallel-load data.
REQ-009 X  output  1  registered sign-extension bit; drives accumulator serial shift-in.
REQ-010 Ld_A  output  1  accumulator parallel-load strobe, one cycle.
REQ-011 Ld_B  output  1  multiplier parallel-load strobe (loads S), one cycle.
REQ-012 Clr_A  output  1  accumulator synchronous-clear strobe, one cycle.
REQ-013 Shift_En  output  1  shift strobe to both downstream registers, one cycle.
REQ-014 Busy  output  1  high in ADD and SHIFT states.
REQ-015 Done  output  1  high in HOLD state.

Function
REQ-016 FSM states SHALL be IDLE, ADD, SHIFT, HOLD; 3-bit counter cnt SHALL index partial product 0..7.
REQ-017 IDLE with Clr_Ld=1: assert Clr_A and Ld_B for that cycle, clear X, remain IDLE.
REQ-018 IDLE with Run=1 and Clr_Ld=0: next state ADD, cnt=0; Clr_Ld=1 SHALL take priority over Run in the same cycle.
REQ-019 Sum9 (9 bits) SHALL be {A[7],A}+{S[7],S} when cnt<7, {A[7],A}-{S[7],S} when cnt=7; Sum=Sum9[7:0], combinational in all states.
REQ-020 ADD with M=1: assert Ld_A; X <= Sum9[8]. ADD with M=0: no Ld_A, X unchanged; next state SHIFT.
REQ-021 SHIFT: assert Shift_En; cnt <= cnt+1; next state HOLD if cnt=7, else ADD.
REQ-022 Result (A:B, 16-bit signed) SHALL be valid in HOLD; fixed latency 16 cycles from Run-sampling edge to HOLD entry (without REQ-029 feature).
REQ-023 HOLD: Done=1; stay while Run=1; Run=0 -> IDLE; X and downstream contents preserved.
REQ-024 Run and Clr_Ld SHALL be ignored in ADD and SHIFT; Run held high SHALL NOT restart (HOLD requires Run release).
REQ-025 All strobes (Ld_A, Ld_B, Clr_A, Shift_En) SHALL be mutually exclusive in every cycle.
REQ-026 cnt SHALL wrap 7->0 only via HOLD/IDLE; no overflow path.

Reset
REQ-027 Reset low: state IDLE, cnt=0, X=0, Ld_A=Ld_B=Clr_A=Shift_En=Busy=Done=0, asserted asynchronously, including mid-operation.
REQ-028 Reset release SHALL resume in IDLE on the next rising Clk edge; no partial multiplication continues.

Configuration
REQ-029 SKIP_ZERO_ADD_EN defined: ADD with M=0 SHALL assert Shift_En and perform the SHIFT actions in the same cycle (ADD->ADD, or ->HOLD at cnt=7), latency 8+popcount(B) cycles; undefined: fixed 16-cycle sequence per REQ-020..REQ-022.

Verification
REQ-030 Clr_Ld with S=0xFD, then S=0x07, Run -> HOLD with A:B=0xFFEB (7 x -3 = -21), Done=1, 16 cycles.
REQ-031 B=0x80, S=0x80, Run -> A:B=0x4000 (-128 x -128); last cycle subtracts, X=0 in HOLD.
REQ-032 Reset low at cnt=4 in ADD -> all outputs 0 same cycle, IDLE after release, Run not yet released does restart only after next IDLE sample.
REQ-033 Run and Clr_Ld both high in IDLE -> Clr_A=Ld_B=1, state stays IDLE; Run held high through HOLD -> no second multiply until Run=0 then 1.
REQ-034 With SKIP_ZERO_ADD_EN, B=0x01, S=0x05 -> A:B=0x0005, HOLD entered 9 cycles after Run sample; without, 16 cycles, same result.
